// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_signed_a(muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final result selection: restores signs on the unsigned engine output and
// applies the divide-by-zero and signed-overflow results.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  input  logic [XLEN-1:0]   a_raw,
  input  logic              neg_res,
  input  logic              neg_rem,
  input  logic              div_zero,
  input  logic              ovf,
  output logic [XLEN-1:0]   result_fix
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [2*XLEN-1:0] cond_neg_wide(logic [2*XLEN-1:0] v, logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(logic [XLEN-1:0] v, logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  muldiv_op_t          op_e;
  logic [2*XLEN-1:0]   prod_fix;

  assign op_e     = muldiv_op_t'(op);
  assign prod_fix = cond_neg_wide(prod, neg_res);

  always_comb begin
    result_fix = '0;
    case (op_e)
      OP_MUL:                       result_fix = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_fix = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero)  result_fix = '1;
        else if (ovf)  result_fix = MIN_VAL;
        else           result_fix = cond_neg(quo, neg_res);
      end
      OP_REM, OP_REMU: begin
        if (div_zero)  result_fix = a_raw;
        else if (ovf)  result_fix = '0;
        else           result_fix = cond_neg(rem, neg_rem);
      end
      default:         result_fix = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one multiplier or quotient bit per
// cycle on unsigned magnitudes, sign and special cases fixed up in DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            Z,
  output logic            N
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic          accept;

  muldiv_op_t      op_in;
  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;

  muldiv_op_t      op_p0;
  logic [XLEN-1:0] mcand_p0, a_raw_p0;
  logic            neg_res_p0, neg_rem_p0, div_zero_p0, ovf_p0;
  logic [XLEN-1:0] hi_p1, lo_p1;

  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ok;
  logic [XLEN-1:0] div_rem_nxt;
  logic [XLEN-1:0] result_fix;

  // A DONE pulse still counts as busy so start in that cycle is dropped.
  assign accept = (state == IDLE) && !done && start;
  assign busy   = (state != IDLE) || done;
  assign Z      = (result == '0);
  assign N      = result[XLEN-1];

  assign op_in = muldiv_op_t'(op);
  assign sa    = op_signed_a(op_in) && a[XLEN-1];
  assign sb    = op_signed_b(op_in) && b[XLEN-1];
  assign a_mag = sa ? (~a + 1'b1) : a;
  assign b_mag = sb ? (~b + 1'b1) : b;

  // Shift-add step: lo holds the multiplier, product shifts right through hi:lo.
  assign mul_sum = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, mcand_p0} : {(XLEN+1){1'b0}});

  // Restoring step: lo holds the dividend, shifted left into hi; quotient fills lo.
  assign div_shift   = {hi_p1, lo_p1[XLEN-1]};
  assign div_diff    = div_shift - {1'b0, mcand_p0};
  assign div_ok      = ~div_diff[XLEN];
  assign div_rem_nxt = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      done  <= (state == DONE);
      if (state == DONE) result <= result_fix;
      if (accept)             cnt <= CW'(XLEN);
      else if (state == CALC) cnt <= cnt - CW'(1);
    end
  end

  // Stage p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0       <= op_in;
      mcand_p0    <= b_mag;
      a_raw_p0    <= a;
      neg_res_p0  <= sa ^ sb;
      neg_rem_p0  <= sa;
      div_zero_p0 <= (b == '0);
      ovf_p0      <= op_signed_b(op_in) && is_div(op_in) && (a == MIN_VAL) && (b == '1);
    end
  end

  // Stage p1: iterative engine
  always_ff @(posedge clk) begin
    if (accept) begin
      hi_p1 <= '0;
      lo_p1 <= a_mag;
    end else if (state == CALC) begin
      if (is_div(op_p0)) begin
        hi_p1 <= div_rem_nxt;
        lo_p1 <= {lo_p1[XLEN-2:0], div_ok};
      end else begin
        hi_p1 <= mul_sum[XLEN:1];
        lo_p1 <= {mul_sum[0], lo_p1[XLEN-1:1]};
      end
    end
  end

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .op         (op_p0),
    .prod       ({hi_p1, lo_p1}),
    .quo        (lo_p1),
    .rem        (hi_p1),
    .a_raw      (a_raw_p0),
    .neg_res    (neg_res_p0),
    .neg_rem    (neg_rem_p0),
    .div_zero   (div_zero_p0),
    .ovf        (ovf_p0),
    .result_fix (result_fix)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, Z, N;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .Z(Z), .N(N)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  // Reference model straight from the RV32M definitions using wide integers.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      ux = longint'({32'b0, x});
    longint      uy = longint'({32'b0, y});
    longint      p;
    logic [63:0] u;
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin u = {32'b0, x} * {32'b0, y}; return u[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFFFFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle busy stuck got=1 expected=0");
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    start = 1'b1; op = f; a = x; b = y;
    exp_q.push_back(model(f, x, y));
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    chk("busy_after_accept", {63'b0, busy}, 64'd1);
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    int          t;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got result=%h expected no done", result);
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("result", {32'b0, result}, {32'b0, e});
        chk("Z", {63'b0, Z}, {63'b0, (e == 32'h0)});
        chk("N", {63'b0, N}, {63'b0, e[31]});
        chk("latency", 64'(cyc - t), 64'd33);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_result", {32'b0, result}, 64'd0);
    chk("rst_Z", {63'b0, Z}, 64'd1);
    chk("rst_N", {63'b0, N}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFFFFFD);
    do_op(3'd1, 32'h80000000, 32'h80000000);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2);
    do_op(3'd5, 32'd100, 32'd7);
    do_op(3'd7, 32'd100, 32'd7);
    for (int f = 4; f < 8; f++) do_op(3'(f), 32'h1234, 32'h0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF);

    // start hammered while busy must not queue or disturb the latched operands
    do_op(3'd4, 32'hDEADBEEF, 32'h00000123);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
    end
    @(negedge clk);
    start = 1'b0;

    // abort mid-calculation
    do_op(3'd0, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_result", {32'b0, result}, 64'd0);
    chk("abort_Z", {63'b0, Z}, 64'd1);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    do_op(3'd0, 32'd3, 32'd4);

    for (int i = 0; i < 150; i++) do_op(3'($urandom), pick(), pick());

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the multi-cycle datapath. It executes all eight M-extension operations with an iterative one-bit-per-cycle shift-add / restoring-divide engine and a start/busy/done handshake. The control FSM stalls on `busy` and latches `result` when `done` pulses. Width is parametrised, so the same block serves 32- and 64-bit datapaths.

## Interface
- `XLEN`, 32: operand/result width; must be even and at least 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`, `b`  in  XLEN  rs1/rs2 operands; sampled with `start`.
- `busy`  out  1  high from the edge after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered result; held until the next accepted `start`.
- `Z`  out  1  `result`==0, same semantics as ALU Z.
- `N`  out  1  `result[XLEN-1]`.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE&start -> CALC.
  - CALC counts XLEN iterations, then -> DONE.
  - DONE -> IDLE unconditionally.
- On accept:
  - Latch `op`.
  - Latch operand magnitudes (absolute value for signed operands per op) and the result sign.
  - Load counter = XLEN.
- Multiply: 2·XLEN-bit product register; shift-add one multiplier bit per CALC cycle.
  - MUL takes the low half; MULH/MULHSU/MULHU take the high half, after two's-complement negation of the full 2·XLEN product when the sign flag is set.
  - MULHSU: only `a` is signed.
- Divide: restoring, one quotient bit per CALC cycle; XLEN-bit remainder plus 1 guard bit.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases are resolved in the DONE stage; latency is not shortened:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give `a`.
  - Signed overflow (a = most-negative, b = −1): DIV gives most-negative; REM gives 0.
- `start` while busy: ignored, no queueing.
- `op`/`a`/`b` changes after accept: no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, so `Z`=1 and `N`=0; counter 0.
- Reset asserted mid-operation: aborts on the next edge with all outputs at reset values and no `done` pulse.
- `start` accepted at edge E0:
  - `busy`=1 after E0.
  - `done`=1 and `result` valid after edge E0+XLEN+1.
  - `busy` and `done` fall after E0+XLEN+2.
- Total latency is XLEN+1 cycles from the accepting edge to `done`; at XLEN=32 that is 33.
- Back-to-back: a new `start` can be accepted in the cycle after DONE, i.e. when `busy`=0.
- `start` high during the DONE cycle: ignored.
- `Z`/`N` are combinational from the registered `result` and change only with `result`.

## Structure
- Shared package `muldiv_pkg`:
  - `muldiv_op_t` enum, 3-bit, funct3 values as listed.
  - `muldiv_state_t` enum: IDLE/CALC/DONE.
  - Helper function `is_div(op)`.
  - Helper function `op_signed_a/b(op)`.
- One sub-module: `muldiv_signfix`, combinational.
  - Takes raw product/quotient/remainder, the sign flags, op and the special-case flags.
  - Produces the final XLEN result.
  - It is reused by the DONE stage only.
- Counter width is $clog2(XLEN+1).

## Test plan
- MUL a=7, b=−3 (0xFFFFFFFD) -> `done` after exactly 33 cycles; `result`=0xFFFFFFEB, N=1, Z=0.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=−1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero, a=0x1234:
  - DIV and DIVU -> 0xFFFFFFFF.
  - REM and REMU -> 0x1234.
  - Overflow 0x80000000 / −1: DIV -> 0x80000000; REM -> 0, Z=1.
- `start` pulsed repeatedly while busy -> exactly one `done`; latched operands are unaffected. Back-to-back start in the cycle after DONE is accepted.
- Reset asserted at CALC cycle 10 -> next cycle `busy`=0, `done`=0, `result`=0, no `done` pulse. A fresh MUL 3×4 then returns 12.
